// File: rtl/fifo_sc_byte_packer.sv
// Pops bytes from a single-clock FIFO (1-cycle read latency) and packs N_BYTES of them into
// a word on a valid/ready output; a flush emits the trailing partial word with its byte count.
module fifo_sc_byte_packer #(
   parameter int unsigned N_BYTES = 4,
   parameter int unsigned BW      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic [BW-1:0]         fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_re,
   input  logic                  flush,
   output logic [N_BYTES*BW-1:0] word_out,
   output logic [3:0]            word_bytes,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic                  flush_done,
   output logic                  busy
);

   localparam int unsigned CW = $clog2(N_BYTES + 1) + 1;
   localparam logic [CW-1:0] NB = CW'(N_BYTES);

   typedef enum logic [1:0] {StRun, StDrain, StEmit} state_e;

   state_e                        state_q, state_d;
   logic [N_BYTES-1:0][BW-1:0]    acc_q, acc_d, acc_masked;
   logic [CW-1:0]                 acc_cnt_q, acc_cnt_d, cnt_inc, pop_sum;
   logic                          rd_pend_q;
   logic                          acc_full_q, acc_full_d;
   logic [N_BYTES*BW-1:0]         word_out_q, word_out_d;
   logic [3:0]                    word_bytes_q, word_bytes_d;
   logic                          word_valid_q, word_valid_d;
   logic                          flush_done_q, flush_done_d;
   logic                          out_free;

   assign pop_sum  = acc_cnt_q + CW'(rd_pend_q);
   assign cnt_inc  = acc_cnt_q + CW'(1);
   assign out_free = !word_valid_q || word_ready;

   // In-flight plus held bytes never exceed one word, so acc can never overflow.
   assign fifo_re = !fifo_empty && rst && !clr && (state_q == StRun) && !flush &&
                    !acc_full_q && (pop_sum < NB);

   always_comb begin
      for (int i = 0; i < N_BYTES; i++) begin
         acc_masked[i] = (CW'(i) < acc_cnt_q) ? acc_q[i] : '0;
      end
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      acc_cnt_d    = acc_cnt_q;
      acc_full_d   = acc_full_q;
      word_out_d   = word_out_q;
      word_bytes_d = word_bytes_q;
      word_valid_d = word_valid_q && !word_ready;
      flush_done_d = 1'b0;

      if (acc_full_q) begin
         if (out_free) begin
            word_out_d   = acc_q;
            word_bytes_d = 4'(N_BYTES);
            word_valid_d = 1'b1;
            acc_full_d   = 1'b0;
            acc_cnt_d    = '0;
         end
      end else if (rd_pend_q) begin
         for (int i = 0; i < N_BYTES; i++) begin
            if (acc_cnt_q == CW'(i)) acc_d[i] = fifo_dout;
         end
         acc_cnt_d = cnt_inc;
         if (cnt_inc == NB) begin
            if (out_free) begin
               word_out_d   = acc_d;
               word_bytes_d = 4'(N_BYTES);
               word_valid_d = 1'b1;
               acc_cnt_d    = '0;
            end else begin
               acc_full_d = 1'b1;
            end
         end
      end

      unique case (state_q)
         StRun: begin
            if (flush) state_d = StDrain;
         end
         StDrain: begin
            if (!rd_pend_q && !acc_full_q) begin
               if (acc_cnt_q == '0) begin
                  state_d      = StRun;
                  flush_done_d = 1'b1;
               end else begin
                  state_d = StEmit;
               end
            end
         end
         StEmit: begin
            // Drain guarantees no capture or full word competes for the output here.
            if (out_free) begin
               word_out_d   = acc_masked;
               word_bytes_d = 4'(acc_cnt_q);
               word_valid_d = 1'b1;
               acc_cnt_d    = '0;
               flush_done_d = 1'b1;
               state_d      = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         state_q      <= StRun;
         acc_q        <= '0;
         acc_cnt_q    <= '0;
         rd_pend_q    <= 1'b0;
         acc_full_q   <= 1'b0;
         word_out_q   <= '0;
         word_bytes_q <= '0;
         word_valid_q <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         acc_cnt_q    <= acc_cnt_d;
         rd_pend_q    <= fifo_re;
         acc_full_q   <= acc_full_d;
         word_out_q   <= word_out_d;
         word_bytes_q <= word_bytes_d;
         word_valid_q <= word_valid_d;
         flush_done_q <= flush_done_d;
      end
   end

   assign word_out   = word_out_q;
   assign word_bytes = word_bytes_q;
   assign word_valid = word_valid_q;
   assign flush_done = flush_done_q;
   assign busy       = (acc_cnt_q != '0) || rd_pend_q || word_valid_q || (state_q != StRun);

endmodule
